// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood builder for the dilation/erosion stages.
// Ports: clk, rst, in_valid/in_pixel in; out_valid/window_flat/out_col/out_row/frame_done out.
module window_gen_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_pixel,
  output logic                          out_valid,
  output logic [9*DATA_WIDTH-1:0]       window_flat,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic                          frame_done
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            vld_q;
  logic            fdone_q;
  logic [9*DW-1:0] win_q, win_d;
  logic [CW-1:0]   ocol_q;
  logic [RW-1:0]   orow_q;

  // lb0 holds line r-1, lb1 holds line r-2
  logic [DW-1:0] lb0_q [IMG_WIDTH];
  logic [DW-1:0] lb1_q [IMG_WIDTH];

  // two older columns per window row: [row][0]=c-2, [row][1]=c-1
  logic [DW-1:0] sr_q [3][2];

  logic [DW-1:0] nc [3];
  logic          last_col;
  logic          last_row;
  logic          win_ok;

  always_comb begin
    nc[0]    = lb1_q[col_q];
    nc[1]    = lb0_q[col_q];
    nc[2]    = in_pixel;
    last_col = (col_q == CW'(IMG_WIDTH - 1));
    last_row = (row_q == RW'(IMG_HEIGHT - 1));
    // c>=2 keeps stale previous-line columns out of any window
    win_ok   = (row_q >= RW'(2)) && (col_q >= CW'(2));
    col_d    = col_q;
    row_d    = row_q;
    if (last_col) begin
      col_d = '0;
      row_d = last_row ? '0 : row_q + RW'(1);
    end else begin
      col_d = col_q + CW'(1);
    end
    win_d = '0;
    for (int r = 0; r < 3; r++) begin
      win_d[(r*3+0)*DW +: DW] = sr_q[r][0];
      win_d[(r*3+1)*DW +: DW] = sr_q[r][1];
      win_d[(r*3+2)*DW +: DW] = nc[r];
    end
  end

  // line buffers need no reset: row gating hides unwritten entries
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      vld_q   <= 1'b0;
      fdone_q <= 1'b0;
      win_q   <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      for (int r = 0; r < 3; r++) begin
        sr_q[r][0] <= '0;
        sr_q[r][1] <= '0;
      end
    end else begin
      vld_q   <= in_valid && win_ok;
      fdone_q <= in_valid && last_col && last_row;
      if (in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        for (int r = 0; r < 3; r++) begin
          sr_q[r][0] <= sr_q[r][1];
          sr_q[r][1] <= nc[r];
        end
        if (win_ok) begin
          win_q  <= win_d;
          ocol_q <= col_q - CW'(1);
          orow_q <= row_q - RW'(1);
        end
      end
    end
  end

  assign out_valid   = vld_q;
  assign frame_done  = fdone_q;
  assign window_flat = win_q;
  assign out_col     = ocol_q;
  assign out_row     = orow_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 4x4 frame.
// Checks windows, positions, frame_done, gaps, back-to-back frames, reset.
module tb_window_gen_3x3;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_pixel;
  logic          out_valid;
  logic [9*DW-1:0] window_flat;
  logic [1:0]    out_col;
  logic [1:0]    out_row;
  logic          frame_done;

  window_gen_3x3 #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .window_flat(window_flat),
    .out_col    (out_col),
    .out_row    (out_row),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] flat;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        fd;
  } cap_t;

  cap_t cap[$];
  int   b2b;
  int   stray_fd;
  logic prev_ov;
  int   n_run;
  int   n_fail;

  initial begin
    b2b      = 0;
    stray_fd = 0;
    prev_ov  = 1'b0;
  end

  always @(negedge clk) begin
    if (out_valid) begin
      cap.push_back('{window_flat, out_row, out_col, frame_done});
      if (prev_ov) b2b++;
    end else if (frame_done) begin
      stray_fd++;
    end
    prev_ov = out_valid;
  end

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] pix, input int gap);
    in_valid = 1'b1;
    in_pixel = pix;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input int gap);
    for (int i = 0; i < W*H; i++) send(DW'(base + i + 1), gap);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pixel at (r,c) is base + r*W + c + 1
  function automatic logic [71:0] exp_win(input int base, input int rr,
                                          input int cc);
    logic [71:0] f;
    f = '0;
    for (int k = 0; k < 9; k++)
      f[k*8 +: 8] = 8'(base + (rr - 1 + k/3)*W + (cc - 1 + k%3) + 1);
    return f;
  endfunction

  function automatic int wmax(input logic [71:0] f);
    logic [7:0] w [9];
    int m;
    m = 0;
    for (int k = 0; k < 9; k++) w[k] = f[k*8 +: 8];
    for (int k = 0; k < 9; k++) if (int'(w[k]) > m) m = int'(w[k]);
    return m;
  endfunction

  task automatic verify_frame(input string tag, input int base,
                              input int start);
    cap_t c;
    for (int i = 0; i < 4; i++) begin
      c = (start + i < cap.size()) ? cap[start+i] : '{'0, '0, '0, 1'b0};
      chk({tag, "_win"}, c.flat, exp_win(base, 1 + i/2, 1 + i%2));
      chk({tag, "_row"}, 72'(c.row), 72'(1 + i/2));
      chk({tag, "_col"}, 72'(c.col), 72'(1 + i%2));
      chk({tag, "_fd"}, 72'(c.fd), 72'(i == 3));
    end
  endtask

  localparam logic [71:0] W1 =
    {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
  localparam logic [71:0] W2_1 =
    {8'd111, 8'd110, 8'd109, 8'd107, 8'd106, 8'd105, 8'd103, 8'd102, 8'd101};

  initial begin
    int s;
    int bs;
    int mx [4];
    n_run    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    idle(2);
    chk("rst_valid", 72'(out_valid), 72'(0));
    chk("rst_win", window_flat, 72'(0));
    chk("rst_col", 72'(out_col), 72'(0));
    chk("rst_row", 72'(out_row), 72'(0));
    chk("rst_fd", 72'(frame_done), 72'(0));
    rst = 1'b0;
    idle(1);

    // 1: continuous frame
    s = cap.size();
    for (int i = 0; i < 11; i++) send(DW'(i + 1), 0);
    chk("s1_lat_valid", 72'(out_valid), 72'(1));
    chk("s1_lat_win", window_flat, W1);
    for (int i = 11; i < 16; i++) send(DW'(i + 1), 0);
    idle(3);
    chk("s1_count", 72'(cap.size() - s), 72'(4));
    chk("s1_first", (s < cap.size()) ? cap[s].flat : '0, W1);
    verify_frame("s1", 0, s);
    chk("s1_hold", window_flat, exp_win(0, 2, 2));
    chk("s1_idle_valid", 72'(out_valid), 72'(0));

    // 6: downstream max filter on the scenario 1 windows
    for (int i = 0; i < 4; i++)
      mx[i] = (s + i < cap.size()) ? wmax(cap[s+i].flat) : 0;
    chk("s6_max0", 72'(mx[0]), 72'(11));
    chk("s6_max1", 72'(mx[1]), 72'(12));
    chk("s6_max2", 72'(mx[2]), 72'(15));
    chk("s6_max3", 72'(mx[3]), 72'(16));

    // 2: three idle cycles after each pixel
    s  = cap.size();
    bs = b2b;
    send_frame(0, 3);
    idle(3);
    chk("s2_count", 72'(cap.size() - s), 72'(4));
    verify_frame("s2", 0, s);
    chk("s2_b2b", 72'(b2b - bs), 72'(0));

    // 3: back-to-back frames
    s = cap.size();
    send_frame(0, 0);
    send_frame(100, 0);
    idle(3);
    chk("s3_count", 72'(cap.size() - s), 72'(8));
    verify_frame("s3a", 0, s);
    verify_frame("s3b", 100, s + 4);
    chk("s3_first2", (s + 4 < cap.size()) ? cap[s+4].flat : '0, W2_1);

    // 4: reset mid-frame after pixel 7
    s = cap.size();
    for (int i = 0; i < 7; i++) send(DW'(50 + i), 0);
    rst = 1'b1;
    idle(1);
    chk("s4_rst_valid", 72'(out_valid), 72'(0));
    chk("s4_rst_win", window_flat, 72'(0));
    chk("s4_rst_col", 72'(out_col), 72'(0));
    chk("s4_rst_row", 72'(out_row), 72'(0));
    chk("s4_rst_fd", 72'(frame_done), 72'(0));
    rst = 1'b0;
    chk("s4_pre_count", 72'(cap.size() - s), 72'(0));
    for (int i = 0; i < 10; i++) send(DW'(i + 1), 0);
    chk("s4_early", 72'(cap.size() - s), 72'(0));
    for (int i = 10; i < 16; i++) send(DW'(i + 1), 0);
    idle(3);
    chk("s4_count", 72'(cap.size() - s), 72'(4));
    verify_frame("s4", 0, s);

    chk("stray_fd", 72'(stray_fd), 72'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Streaming neighbourhood builder placed directly upstream of the 3x3 morphological stages (dilation/erosion).
- Accepts one raster-order pixel per valid cycle and buffers the two previous image lines in internal line buffers.
- Presents a registered 3x3 window of 9 pixels plus a valid strobe, one window per interior output position.
- Border positions produce no window, so each frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.

Parameters:
DATA_WIDTH, 8, pixel bit width
IMG_WIDTH, 640, pixels per line (>=3)
IMG_HEIGHT, 480, lines per frame (>=3)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_pixel is valid this cycle
in_pixel  input  DATA_WIDTH  raster-order pixel, left-to-right, top-to-bottom
out_valid  output  1  window bus holds a new window this cycle (1-cycle pulse)
window_flat  output  9*DATA_WIDTH  window element k at bits [k*DATA_WIDTH +: DATA_WIDTH]; k = row*3+col; row 0 = oldest line (top); col 0 = leftmost
out_col  output  $clog2(IMG_WIDTH)  column of the window centre pixel
out_row  output  $clog2(IMG_HEIGHT)  row of the window centre pixel
frame_done  output  1  1-cycle pulse, one cycle after the last pixel of a frame is accepted

Behaviour:
- Reset (rst=1 at clk edge):
  - col_cnt=0, row_cnt=0.
  - out_valid=0, frame_done=0, window_flat=0, out_col=0, out_row=0.
  - Line buffer contents are don't-care and never read before being rewritten, because windows are gated by row_cnt.
- No backpressure: the consumer must accept every out_valid pulse.
- in_valid=0: no state changes. out_valid and frame_done drop to 0 on the next cycle. window_flat holds its value.
- On each in_valid=1 at position (r,c) = (row_cnt,col_cnt):
  - lb1[c] is written with lb0[c] (old value).
  - lb0[c] is written with in_pixel.
  - Line buffers are IMG_WIDTH-deep arrays: lb0 = line r-1, lb1 = line r-2, read and written at the same address in the same cycle (read-before-write).
  - Three 3-deep column shift registers (top/mid/bottom) shift left.
  - New rightmost column = {lb1[c], lb0[c], in_pixel}.
- Window-complete condition: r>=2 and c>=2.
  - Next cycle: out_valid=1 and window_flat = rows r-2..r, columns c-2..c.
  - out_col=c-1, out_row=r-1.
  - Latency is 1 clk from accepting the completing pixel to out_valid.
- Counter wrap:
  - c==IMG_WIDTH-1 -> col_cnt=0 and row_cnt increments.
  - Additionally, r==IMG_HEIGHT-1 -> row_cnt=0, and frame_done pulses on the next cycle (coincident with the final out_valid).
  - The next frame starts with no gap required.
- Row boundaries: the shift registers contain stale previous-line pixels at c=0,1, but c>=2 gating prevents any window from spanning two lines.
- Gaps in in_valid anywhere, including mid-line, do not alter window content or ordering.
- Reset mid-frame: the first pixel after reset release is treated as (0,0). No window is emitted until a new (2,2) is reached.
- Arithmetic: counters are unsigned and sized $clog2 of their range. No pixel arithmetic is performed; data is passed through bit-exact.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=4, continuous in_valid, pixel=row*4+col+1 (1..16) -> exactly 4 out_valid pulses:
   - 1st window = {1,2,3,5,6,7,9,10,11} at out_row=1, out_col=1, one cycle after pixel 11.
   - 2nd = {2,3,4,6,7,8,10,11,12}.
   - 3rd = {5,6,7,9,10,11,13,14,15}.
   - 4th = {6,7,8,10,11,12,14,15,16}, with frame_done=1 in the same cycle.
2. Same frame with in_valid low for 3 cycles after every pixel -> identical 4 windows in the same order; out_valid is never high for 2 consecutive cycles.
3. Two back-to-back frames, second frame pixel=100+index -> second frame's first window = {101,102,103,105,106,107,109,110,111}; no window mixes pixels from the two frames.
4. Assert rst after pixel 7 of frame 1, then send a full frame -> no out_valid before the restarted (2,2) pixel; then the 4 windows of scenario 1; outputs are 0 during reset.
5. Default parameters (640x480), random pixels, compared against a golden model -> 638*478=304964 windows, all bit-exact, exactly one frame_done.
6. Chain with the downstream max-filter (window_flat unpacked), using the scenario 1 frame -> dilated outputs 11,12,15,16.
